// File: rtl/riscv_pkg.sv
// riscv_pkg
// Shared definitions for the unified-memory arbiter: requester index
// constants, the grant-id width and the arbiter FSM state encoding.
`timescale 1ns/1ps

package riscv_pkg;

    localparam int ARB_IDW = 2;

    localparam logic [ARB_IDW-1:0] REQ_LOADER = 2'd0;
    localparam logic [ARB_IDW-1:0] REQ_DATA   = 2'd1;
    localparam logic [ARB_IDW-1:0] REQ_IFETCH = 2'd2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_ACK   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/arb_pick.sv
// arb_pick
// Combinational winner selection among NREQ request lines.
//   i_req   : request level per requester
//   i_last  : index of the most recently granted requester
//   o_win   : index of the winning requester (0 when none)
//   o_valid : at least one request is pending
// MEMARB_RR_EN defined   : round robin, the requester after i_last wins.
// MEMARB_RR_EN undefined : fixed priority, lowest index wins; i_last ignored.
`timescale 1ns/1ps

module arb_pick
    import riscv_pkg::*;
#(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0]    i_req,
    input  logic [ARB_IDW-1:0] i_last,
    output logic [ARB_IDW-1:0] o_win,
    output logic               o_valid
);

    assign o_valid = |i_req;

`ifdef MEMARB_RR_EN
    logic [ARB_IDW-1:0] w_hi_win;
    logic               w_hi_valid;
    logic [ARB_IDW-1:0] w_lo_win;

    // Requesters above the pointer take precedence; if none of them is
    // asking, the search wraps to the lowest requesting index.
    always_comb begin
        w_hi_win   = '0;
        w_hi_valid = 1'b0;
        w_lo_win   = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (i_req[i] && (i > int'(i_last))) begin
                w_hi_win   = ARB_IDW'(i);
                w_hi_valid = 1'b1;
            end
            if (i_req[i]) begin
                w_lo_win = ARB_IDW'(i);
            end
        end
    end

    assign o_win = w_hi_valid ? w_hi_win : w_lo_win;
`else
    logic w_unused_last;
    assign w_unused_last = ^i_last;

    always_comb begin
        o_win = '0;
        for (int i = NREQ-1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_win = ARB_IDW'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares one single-port memory between NREQ requesters (loader, core data,
// core ifetch). One request is latched at a time, strobed to memory, and
// acknowledged with a one-cycle pulse MEM_LAT+1 cycles after acceptance.
//   clk, reset            : clock, async active-high reset
//   req/req_we            : per-requester request level and write flag
//   req_addr/req_wdata    : per-requester address / write data, 32b each
//   ack                   : one-hot completion pulse
//   rdata                 : read data, valid while ack is high
//   gnt_id                : requester owning the memory
//   busy                  : high whenever not idle
//   mem_en/mem_we         : memory strobe / write enable
//   mem_addr/mem_wdata    : latched address / write data
//   mem_rdata             : memory read data
// Build option: MEMARB_RR_EN selects round-robin arbitration instead of
// fixed priority.
//
// state     | meaning
// ARB_IDLE  | waiting for a request, winner latched on exit
// ARB_ISSUE | mem_en strobe, latency counter loaded
// ARB_WAIT  | counting down memory latency, read data captured on exit
// ARB_ACK   | one-cycle ack to the granted requester
`timescale 1ns/1ps

module mem_arbiter
    import riscv_pkg::*;
#(
    parameter int NREQ    = 3,
    parameter int MEM_LAT = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*32-1:0]   req_addr,
    input  logic [NREQ*32-1:0]   req_wdata,
    output logic [NREQ-1:0]      ack,
    output logic [31:0]          rdata,
    output logic [ARB_IDW-1:0]   gnt_id,
    output logic                 busy,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    input  logic [31:0]          mem_rdata
);

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    arb_state_t          r_state;
    logic [3:0]          r_cnt;
    logic [NREQ-1:0]     r_ack;
    logic [31:0]         r_rdata;
    logic [ARB_IDW-1:0]  r_gnt_id;
    logic                r_busy;
    logic                r_mem_en;
    logic                r_mem_we;
    logic [31:0]         r_mem_addr;
    logic [31:0]         r_mem_wdata;

    logic [ARB_IDW-1:0]  w_win;
    logic                w_valid;
    logic [ARB_IDW-1:0]  w_last;
    logic                w_sel_we;
    logic [31:0]         w_sel_addr;
    logic [31:0]         w_sel_wdata;
    logic [NREQ-1:0]     w_ack_hot;

`ifdef MEMARB_RR_EN
    logic [ARB_IDW-1:0]  r_last;
    assign w_last = r_last;
`else
    assign w_last = ARB_IDW'(NREQ - 1);
`endif

    arb_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .i_req   (req),
        .i_last  (w_last),
        .o_win   (w_win),
        .o_valid (w_valid)
    );

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_win == ARB_IDW'(i)) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*32 +: 32];
                w_sel_wdata = req_wdata[i*32 +: 32];
            end
        end
    end

    always_comb begin
        w_ack_hot = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_ack_hot[i] = (r_gnt_id == ARB_IDW'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ARB_IDLE;
            r_cnt       <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_gnt_id    <= REQ_LOADER;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef MEMARB_RR_EN
            r_last      <= ARB_IDW'(NREQ - 1);
`endif
        end else begin
            r_mem_en <= 1'b0;
            r_ack    <= '0;
            case (r_state)
                ARB_IDLE: begin
                    if (w_valid) begin
                        r_gnt_id    <= w_win;
                        r_mem_we    <= w_sel_we;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_en    <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ARB_ISSUE;
`ifdef MEMARB_RR_EN
                        r_last      <= w_win;
`endif
                    end
                end
                ARB_ISSUE: begin
                    r_cnt <= LAT_LOAD;
                    // Single-cycle memory: data is already valid alongside the strobe.
                    if (MEM_LAT == 1) begin
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_ack   <= w_ack_hot;
                        r_state <= ARB_ACK;
                    end else begin
                        r_state <= ARB_WAIT;
                    end
                end
                ARB_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt <= 4'd1) begin
                        if (!r_mem_we) begin
                            r_rdata <= mem_rdata;
                        end
                        r_ack   <= w_ack_hot;
                        r_state <= ARB_ACK;
                    end
                end
                ARB_ACK: begin
                    r_busy  <= 1'b0;
                    r_state <= ARB_IDLE;
                end
                default: begin
                    r_state <= ARB_IDLE;
                end
            endcase
        end
    end

    assign ack       = r_ack;
    assign rdata     = r_rdata;
    assign gnt_id    = r_gnt_id;
    assign busy      = r_busy;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps

module tb_mem_arbiter;
    import riscv_pkg::*;

    localparam int NREQ    = 3;
    localparam int MEM_LAT = 2;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [NREQ-1:0]    req = '0;
    logic [NREQ-1:0]    req_we = '0;
    logic [NREQ*32-1:0] req_addr = '0;
    logic [NREQ*32-1:0] req_wdata = '0;
    logic [NREQ-1:0]    ack;
    logic [31:0]        rdata;
    logic [1:0]         gnt_id;
    logic               busy;
    logic               mem_en;
    logic               mem_we;
    logic [31:0]        mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata = '0;

    int n_pass  = 0;
    int n_total = 0;
    int cyc     = 0;
    bit chk_en  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mem_arbiter #(.NREQ(NREQ), .MEM_LAT(MEM_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rdata     (rdata),
        .gnt_id    (gnt_id),
        .busy      (busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // background contents of every memory word
    function automatic logic [31:0] pat(int w);
        return (w == 64) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(w));
    endfunction

    // memory macro: one register stage, so data is ready for MEM_LAT=2
    logic [31:0] ram [int];
    always @(posedge clk) begin
        int w;
        if (mem_en) begin
            w = int'(mem_addr[11:2]);
            if (mem_we) ram[w] = mem_wdata;
            else        mem_rdata <= ram.exists(w) ? ram[w] : pat(w);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        else n_pass++;
    endtask

    // ---------------- transaction-level reference model ----------------
    bit          m_active = 1'b0;
    int          m_t = 0;            // cycles since acceptance (1 = strobe cycle)
    logic [1:0]  m_id = '0;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0, m_pend = '0;
    int          m_ptr = NREQ - 1;
    logic [31:0] gold [int];

    function automatic int pick(logic [NREQ-1:0] r, int last);
        if (r == '0 || last < 0) return -1;
`ifdef MEMARB_RR_EN
        for (int k = 1; k <= NREQ; k++) if (r[(last + k) % NREQ]) return (last + k) % NREQ;
`else
        for (int i = 0; i < NREQ; i++) if (r[i]) return i;
`endif
        return -1;
    endfunction

    always @(posedge clk or posedge reset) begin
        int w;
        int a;
        if (reset) begin
            m_active = 1'b0; m_t = 0; m_id = '0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0; m_ptr = NREQ - 1;
        end else if (m_active) begin
            if (m_t == MEM_LAT + 1) m_active = 1'b0;
            else begin
                m_t++;
                if (m_t == MEM_LAT + 1 && !m_we) m_rdata = m_pend;
            end
        end else begin
            w = pick(req, m_ptr);
            if (w >= 0) begin
                m_active = 1'b1; m_t = 1; m_id = 2'(w); m_ptr = w;
                m_we = req_we[w]; m_addr = req_addr[w*32 +: 32]; m_wdata = req_wdata[w*32 +: 32];
                a = int'(m_addr[11:2]);
                if (m_we) gold[a] = m_wdata;
                else m_pend = gold.exists(a) ? gold[a] : pat(a);
            end
        end
    end

    always @(negedge clk) begin
        logic [NREQ-1:0] e_ack;
        if (chk_en) begin
            e_ack = (m_active && m_t == MEM_LAT + 1) ? (NREQ'(1) << m_id) : '0;
            check("ack",       32'(ack),    32'(e_ack));
            check("busy",      32'(busy),   32'(m_active));
            check("mem_en",    32'(mem_en), 32'(m_active && m_t == 1));
            check("gnt_id",    32'(gnt_id), 32'(m_id));
            check("mem_we",    32'(mem_we), 32'(m_we));
            check("mem_addr",  mem_addr,  m_addr);
            check("mem_wdata", mem_wdata, m_wdata);
            check("rdata",     rdata,     m_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic txn(input int id, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output int en_k, output int ack_k, output logic [31:0] rd,
                       output logic en_we, output logic [31:0] en_wd);
        req_we[id] = we; req_addr[id*32 +: 32] = addr; req_wdata[id*32 +: 32] = wd; req[id] = 1'b1;
        en_k = -1; ack_k = -1; rd = '0; en_we = 1'b0; en_wd = '0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (mem_en && en_k < 0) begin en_k = k; en_we = mem_we; en_wd = mem_wdata; end
            if (ack[id]) begin ack_k = k; rd = rdata; break; end
        end
        @(posedge clk); #1;
        req[id] = 1'b0;
    endtask

    int          en_k, ack_k, n_ack;
    logic [31:0] rd, ewd;
    logic        ew;
    int          ord [4];
    int          acyc [4];
    logic [NREQ-1:0] drop;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_ack",   32'(ack),  32'd0);
        check("rst_rdata", rdata,     32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // single read
        txn(1, 1'b0, 32'h100, 32'h0, en_k, ack_k, rd, ew, ewd);
        check("rd_en_cycle",  32'(en_k),  32'd1);
        check("rd_ack_cycle", 32'(ack_k), 32'd3);
        check("rd_data",      rd,         32'hDEADBEEF);

        // write then read back
        txn(0, 1'b1, 32'h40, 32'h55AA55AA, en_k, ack_k, rd, ew, ewd);
        check("wr_en_cycle",  32'(en_k),  32'd1);
        check("wr_ack_cycle", 32'(ack_k), 32'd3);
        check("wr_mem_we",    32'(ew),    32'd1);
        check("wr_mem_wdata", ewd,        32'h55AA55AA);
        txn(1, 1'b0, 32'h40, 32'h0, en_k, ack_k, rd, ew, ewd);
        check("rdback_data",  rd,         32'h55AA55AA);

        // three-way contention, each drops its request after its ack
        for (int i = 0; i < NREQ; i++) begin
            req_we[i] = 1'b0; req_addr[i*32 +: 32] = 32'h1000 + 32'(16 * i);
        end
        req = '1;
        n_ack = 0;
        for (int c = 0; c < 60 && n_ack < 3; c++) begin
            @(negedge clk);
            drop = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && n_ack < 4) begin ord[n_ack] = i; acyc[n_ack] = cyc; n_ack++; drop[i] = 1'b1; end
            end
            if (drop != '0) begin @(posedge clk); #1; req = req & ~drop; end
        end
        check("cont_nack", 32'(n_ack), 32'd3);
        check("cont_ord0", 32'(ord[0]), 32'd0);
        check("cont_ord1", 32'(ord[1]), 32'd1);
        check("cont_ord2", 32'(ord[2]), 32'd2);
        check("cont_gap1", 32'(acyc[1] - acyc[0]), 32'd4);
        check("cont_gap2", 32'(acyc[2] - acyc[1]), 32'd4);
        req = '0;

        // requesters 1 and 2 held continuously
        req_we = '0; req_addr[32 +: 32] = 32'h2000; req_addr[64 +: 32] = 32'h3000;
        req = 3'b110;
        n_ack = 0;
        for (int c = 0; c < 60 && n_ack < 4; c++) begin
            @(negedge clk);
            for (int i = 0; i < NREQ; i++) begin
                if (ack[i] && n_ack < 4) begin ord[n_ack] = i; n_ack++; end
            end
        end
        @(posedge clk); #1;
        req = '0;
        check("hold_nack", 32'(n_ack), 32'd4);
`ifdef MEMARB_RR_EN
        check("rr_ord0", 32'(ord[0]), 32'd1);
        check("rr_ord1", 32'(ord[1]), 32'd2);
        check("rr_ord2", 32'(ord[2]), 32'd1);
        check("rr_ord3", 32'(ord[3]), 32'd2);
`else
        check("fix_ord0", 32'(ord[0]), 32'd1);
        check("fix_ord1", 32'(ord[1]), 32'd1);
        check("fix_ord2", 32'(ord[2]), 32'd1);
        check("fix_ord3", 32'(ord[3]), 32'd1);
`endif
        for (int c = 0; c < 20 && busy; c++) @(negedge clk);
        check("hold_drain_idle", 32'(busy), 32'd0);
        @(posedge clk); #1;

        // reset during WAIT
        req_we[2] = 1'b0; req_addr[64 +: 32] = 32'h200; req[2] = 1'b1;
        @(negedge clk);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        check("abort_busy",   32'(busy),   32'd0);
        check("abort_mem_en", 32'(mem_en), 32'd0);
        check("abort_addr",   mem_addr,    32'd0);
        @(negedge clk);
        check("abort_no_ack", 32'(ack),    32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        ack_k = -1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (ack[2]) begin ack_k = k; rd = rdata; break; end
        end
        check("after_rst_ack_cycle", 32'(ack_k), 32'd3);
        check("after_rst_rdata",     rd,          32'h10000080);
        @(posedge clk); #1;
        req[2] = 1'b0;

        // request dropped during WAIT still completes
        req_we[2] = 1'b0; req_addr[64 +: 32] = 32'h300; req[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(negedge clk);
        check("early_wait_no_ack", 32'(ack), 32'd0);
        @(negedge clk);
        check("early_ack",   32'(ack), 32'b100);
        check("early_rdata", rdata,    32'h100000C0);
        @(negedge clk);
        check("early_idle",  32'(busy), 32'd0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between three requesters: the program loader (0), the core's data port (1) and the core's instruction fetch (2). It sits between the CPU top level and the memory macro. It latches one winning request at a time, issues it to memory, waits a fixed memory latency and returns a one-cycle acknowledge with read data. The core stalls on `busy`/missing `ack`.

## Interface

Parameters:
- `NREQ`, 3, number of requesters; index 0 has highest fixed priority.
- `MEM_LAT`, 2, cycles from `mem_en` to valid `mem_rdata`; legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `req`  in  NREQ  request level per requester, held until its `ack`.
- `req_we`  in  NREQ  1 = write, 0 = read, per requester.
- `req_addr`  in  NREQ*32  byte address, requester i at bits [32i+31:32i].
- `req_wdata`  in  NREQ*32  write data, same packing.
- `ack`  out  NREQ  one-hot, one-cycle completion pulse.
- `rdata`  out  32  read data, valid while `ack` is high.
- `gnt_id`  out  2  index of the requester currently owning memory.
- `busy`  out  1  high in every state except IDLE.
- `mem_en`  out  1  one-cycle memory strobe.
- `mem_we`  out  1  memory write enable, qualified by `mem_en`.
- `mem_addr`  out  32  latched address.
- `mem_wdata`  out  32  latched write data.
- `mem_rdata`  in  32  memory read data, valid `MEM_LAT` cycles after `mem_en`.

## Operation

- FSM states: IDLE → ISSUE → WAIT → ACK → IDLE.
- IDLE:
  - If any `req` bit is set, pick the winner. Latch its we/addr/wdata into registers and set `gnt_id`. Go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE: `mem_en`=1 and `mem_we`=latched we. Load the latency counter with `MEM_LAT`-1. Go to WAIT, or go straight to ACK when `MEM_LAT`=1.
- WAIT: decrement the counter. At 0, capture `mem_rdata` into `rdata` (read only) and go to ACK.
- ACK: `ack[gnt_id]`=1 for exactly this cycle. Go to IDLE.
- Writes still get an `ack`. `rdata` keeps its previous value on writes.
- Requester contract: fields stay stable while `req` is high. If `req` drops before `ack`, the latched transaction still completes and still gets its `ack`.
- Requests arriving while `busy` wait. No request is ever lost or reordered within one requester.
- Reset values:
  - outputs: `ack`=0, `rdata`=0, `gnt_id`=0, `busy`=0, `mem_en`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0.
  - internal: state IDLE, counter 0.
- Reset mid-transaction aborts it with no `ack`. A memory write already strobed may have taken effect.

## Timing

- `req` sampled in IDLE at cycle N: ISSUE at N+1, ACK at N+1+`MEM_LAT`, IDLE at N+2+`MEM_LAT`.
- Minimum back-to-back spacing is `MEM_LAT`+2 cycles per transaction.
- A requester holding `req` high through its ACK cycle is treated as a new request. It can be re-accepted in the following IDLE cycle.
- `mem_addr`, `mem_we` and `mem_wdata` stay stable from ISSUE through ACK.

## Configuration

- `MEMARB_RR_EN` defined:
  - round-robin pick; the requester after the last granted one has highest priority.
  - the last-granted pointer resets to NREQ-1, so requester 0 wins the first contention.
  - the pointer updates only on entry to ISSUE.
- `MEMARB_RR_EN` undefined: fixed priority, lowest index wins. No pointer register exists.

## Structure

- Shared package `riscv_pkg`:
  - requester index constants `REQ_LOADER`=0, `REQ_DATA`=1, `REQ_IFETCH`=2.
  - FSM state encoding `ARB_IDLE`/`ARB_ISSUE`/`ARB_WAIT`/`ARB_ACK`.
- Sub-module `arb_pick`: combinational. Inputs are `req` and the last-granted pointer; outputs are winner index and valid. Both priority modes live inside it under the macro.

## Test plan

- Single read, `MEM_LAT`=2: requester 1 reads 0x100 and memory returns 0xDEADBEEF → `mem_en` at N+1, `ack[1]` at N+3, `rdata`=0xDEADBEEF.
- Write: requester 0 writes 0x55AA55AA to 0x40 → one `mem_en` with `mem_we`=1 and `mem_wdata`=0x55AA55AA, `ack[0]` at N+3. A subsequent read of 0x40 returns 0x55AA55AA.
- Contention, fixed priority: all three `req` high together → ack order 0, 1, 2, with acks 4 cycles apart.
- Contention under `MEMARB_RR_EN`: requesters 1 and 2 held high continuously → acks alternate 1, 2, 1, 2. Requester 1 is never granted twice in a row while 2 waits.
- Reset during WAIT: assert `reset` one cycle after ISSUE → all outputs 0 immediately, no `ack`. The next request completes normally with `MEM_LAT`+1 latency.
- `req` dropped early: requester 2 deasserts `req` during WAIT → `ack[2]` still pulses at the normal cycle, then IDLE.
